// File: rtl/sram_ctrl_param.sv
// Sequencer for an SRAM macro with in-memory compute: read, write and IMC wordline/precharge/sense timing.
// Every output is registered and follows the state being entered; start is only honoured in IDLE.
module sram_ctrl_param #(
  parameter int ROWS         = 16,
  parameter int COLS         = 16,
  parameter int PRE_CYC      = 1,
  parameter int IMC_EVAL_CYC = 4,
  localparam int AW          = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [AW-1:0]   addr,
  input  logic [ROWS-1:0] ib_in,
  input  logic [COLS-1:0] col_mask,
  output logic [ROWS-1:0] wwl,
  output logic            we,
  output logic            pre_sram,
  output logic            pre_vlsa,
  output logic            pre_clsa,
  output logic [COLS-1:0] pre_a,
  output logic [COLS-1:0] en,
  output logic [ROWS-1:0] rwl,
  output logic [ROWS-1:0] rwlb,
  output logic            saen,
  output logic            data_ready,
  output logic            done,
  output logic            busy,
  output logic            err,
  output logic [3:0]      state
);

  localparam int CMAX = (PRE_CYC > IMC_EVAL_CYC) ? PRE_CYC : IMC_EVAL_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_CYC - 1);
  localparam logic [CW-1:0] EVAL_LAST = CW'(IMC_EVAL_CYC - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RD_PRE   = 4'd1,  RD_WL    = 4'd2,  RD_SNS  = 4'd3,  RD_REL  = 4'd4,
    WR_PRE   = 4'd5,  WR_DRV   = 4'd6,  WR_WL   = 4'd7,  WR_REL  = 4'd8,
    IMC_PRE  = 4'd9,  IMC_EVAL = 4'd10, IMC_LAT = 4'd11, IMC_SNS = 4'd12,
    IMC_REL  = 4'd13
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [ROWS-1:0] ib_q, ib_d;
  logic [COLS-1:0] mask_q, mask_d;

  logic [ROWS-1:0] wwl_q, wwl_d, rwl_q, rwl_d, rwlb_q, rwlb_d;
  logic [COLS-1:0] pre_a_q, pre_a_d, en_q, en_d;
  logic we_q, we_d, pre_sram_q, pre_sram_d, pre_vlsa_q, pre_vlsa_d;
  logic pre_clsa_q, pre_clsa_d, saen_q, saen_d, data_ready_q, data_ready_d;
  logic done_q, done_d, busy_q, busy_d, err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    addr_d  = addr_q;
    ib_d    = ib_q;
    mask_d  = mask_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == 2'b11) begin
            err_d = 1'b1;
          end else begin
            addr_d = addr;
            ib_d   = ib_in;
            mask_d = col_mask;
            case (op)
              2'b00:   state_d = RD_PRE;
              2'b01:   state_d = WR_PRE;
              default: state_d = IMC_PRE;
            endcase
          end
        end
      end
      RD_PRE:   if (cnt_q == PRE_LAST) state_d = RD_WL; else cnt_d = cnt_q + CW'(1);
      RD_WL:    state_d = RD_SNS;
      RD_SNS:   state_d = RD_REL;
      RD_REL:   state_d = IDLE;
      WR_PRE:   if (cnt_q == PRE_LAST) state_d = WR_DRV; else cnt_d = cnt_q + CW'(1);
      WR_DRV:   state_d = WR_WL;
      WR_WL:    state_d = WR_REL;
      WR_REL:   state_d = IDLE;
      IMC_PRE:  state_d = IMC_EVAL;
      IMC_EVAL: if (cnt_q == EVAL_LAST) state_d = IMC_LAT; else cnt_d = cnt_q + CW'(1);
      IMC_LAT:  state_d = IMC_SNS;
      IMC_SNS:  state_d = IMC_REL;
      IMC_REL:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Outputs are decoded from the state being entered so they line up with it once registered.
    wwl_d        = '0;
    we_d         = 1'b0;
    pre_sram_d   = 1'b1;
    pre_vlsa_d   = 1'b1;
    pre_clsa_d   = 1'b1;
    pre_a_d      = '1;
    en_d         = '0;
    rwl_d        = '0;
    rwlb_d       = '0;
    saen_d       = 1'b0;
    data_ready_d = 1'b0;
    done_d       = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_d)
      RD_PRE: begin
        pre_sram_d = 1'b0;
        pre_vlsa_d = 1'b0;
      end
      RD_WL:  wwl_d = ROWS'(1) << addr_d;
      RD_SNS: begin
        wwl_d        = ROWS'(1) << addr_d;
        data_ready_d = 1'b1;
      end
      WR_PRE: pre_sram_d = 1'b0;
      WR_DRV: we_d = 1'b1;
      WR_WL: begin
        we_d  = 1'b1;
        wwl_d = ROWS'(1) << addr_d;
      end
      RD_REL, WR_REL, IMC_REL: done_d = 1'b1;
      IMC_EVAL, IMC_LAT, IMC_SNS: begin
        rwl_d      = ib_d;
        rwlb_d     = ~ib_d;
        en_d       = mask_d;
        pre_a_d    = '0;
        pre_clsa_d = (state_d != IMC_EVAL);
        saen_d     = (state_d == IMC_SNS);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      ib_q         <= '0;
      mask_q       <= '0;
      wwl_q        <= '0;
      we_q         <= 1'b0;
      pre_sram_q   <= 1'b1;
      pre_vlsa_q   <= 1'b1;
      pre_clsa_q   <= 1'b1;
      pre_a_q      <= '1;
      en_q         <= '0;
      rwl_q        <= '0;
      rwlb_q       <= '0;
      saen_q       <= 1'b0;
      data_ready_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      ib_q         <= ib_d;
      mask_q       <= mask_d;
      wwl_q        <= wwl_d;
      we_q         <= we_d;
      pre_sram_q   <= pre_sram_d;
      pre_vlsa_q   <= pre_vlsa_d;
      pre_clsa_q   <= pre_clsa_d;
      pre_a_q      <= pre_a_d;
      en_q         <= en_d;
      rwl_q        <= rwl_d;
      rwlb_q       <= rwlb_d;
      saen_q       <= saen_d;
      data_ready_q <= data_ready_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign wwl        = wwl_q;
  assign we         = we_q;
  assign pre_sram   = pre_sram_q;
  assign pre_vlsa   = pre_vlsa_q;
  assign pre_clsa   = pre_clsa_q;
  assign pre_a      = pre_a_q;
  assign en         = en_q;
  assign rwl        = rwl_q;
  assign rwlb       = rwlb_q;
  assign saen       = saen_q;
  assign data_ready = data_ready_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Scoreboard bench for sram_ctrl_param (PRE_CYC=2, IMC_EVAL_CYC=4): stimulus queues expected
// per-operation signatures, a negedge monitor measures each operation and compares.
module tb_sram_ctrl_param;

  logic        clk, reset, start;
  logic [1:0]  op;
  logic [3:0]  addr;
  logic [15:0] ib_in, col_mask;
  logic [15:0] wwl, pre_a, en, rwl, rwlb;
  logic        we, pre_sram, pre_vlsa, pre_clsa, saen, data_ready, done, busy, err;
  logic [3:0]  state;

  sram_ctrl_param #(.ROWS(16), .COLS(16), .PRE_CYC(2), .IMC_EVAL_CYC(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .ib_in(ib_in),
    .col_mask(col_mask), .wwl(wwl), .we(we), .pre_sram(pre_sram), .pre_vlsa(pre_vlsa),
    .pre_clsa(pre_clsa), .pre_a(pre_a), .en(en), .rwl(rwl), .rwlb(rwlb), .saen(saen),
    .data_ready(data_ready), .done(done), .busy(busy), .err(err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id, lat, nbusy, nwe, wwl_m, wwl_nz, rwl_m, rwl_nz, dr_k, saen_k, nsram, nvlsa, nclsa, npa0;
    logic [15:0] wwl_v, rwl_v, rwlb_v, en_v;
    bit is_err, abort, b2b;
  } exp_t;

  exp_t sb[$];
  exp_t cur, obs;
  int   nchecks = 0, nerr = 0, next_id = 1;
  int   cyc = 0, last_done = 0, k = 0;
  bit   in_op = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_state"}, int'(state), 0);      chk({t, "_wwl"}, int'(wwl), 0);
    chk({t, "_we"}, int'(we), 0);            chk({t, "_pre_sram"}, int'(pre_sram), 1);
    chk({t, "_pre_vlsa"}, int'(pre_vlsa), 1); chk({t, "_pre_clsa"}, int'(pre_clsa), 1);
    chk({t, "_pre_a"}, int'(pre_a), 16'hFFFF); chk({t, "_en"}, int'(en), 0);
    chk({t, "_rwl"}, int'(rwl), 0);          chk({t, "_rwlb"}, int'(rwlb), 0);
    chk({t, "_saen"}, int'(saen), 0);        chk({t, "_data_ready"}, int'(data_ready), 0);
    chk({t, "_done"}, int'(done), 0);        chk({t, "_busy"}, int'(busy), 0);
    chk({t, "_err"}, int'(err), 0);
  endtask

  // Signatures below are counted by hand from the state sequence with PRE_CYC=2, IMC_EVAL_CYC=4.
  task automatic do_op(input logic [1:0] o, input logic [3:0] a, input logic [15:0] ib,
                       input logic [15:0] m, input bit b2b, input bit abort);
    exp_t e;
    e = '{default: 0};
    e.id = next_id++; e.b2b = b2b; e.abort = abort;
    case (o)
      2'b00: begin
        e.lat = 5; e.nbusy = 5; e.wwl_v = 16'(1) << a; e.wwl_m = 2; e.wwl_nz = 2;
        e.dr_k = 4; e.nsram = 2; e.nvlsa = 2;
      end
      2'b01: begin
        e.lat = 5; e.nbusy = 5; e.nwe = 2; e.wwl_v = 16'(1) << a; e.wwl_m = 1; e.wwl_nz = 1;
        e.nsram = 2;
      end
      2'b10: begin
        e.lat = 8; e.nbusy = 8; e.rwl_v = ib; e.rwlb_v = ~ib; e.en_v = m;
        e.rwl_m = 6; e.rwl_nz = 6; e.saen_k = 7; e.nclsa = 4; e.npa0 = 6;
      end
      default: e.is_err = 1;
    endcase
    @(posedge clk); #1;
    sb.push_back(e);
    start = 1'b1; op = o; addr = a; ib_in = ib; col_mask = m;
    @(posedge clk); #1;
    start = 1'b0; op = 2'b10; addr = ~a; ib_in = ~ib; col_mask = ~m;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", int'(seen), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (in_op) begin
        chk($sformatf("op%0d_abort", cur.id), int'(cur.abort), 1);
        in_op = 0;
      end
    end else begin
      cyc++;
      chk("wwl_onehot0", int'((wwl & (wwl - 16'd1)) == 16'd0), 1);
      chk("wwl_rwl_excl", int'(wwl != 0 && rwl != 0), 0);
      chk("we_in_write", int'(we && !(state >= 4'd5 && state <= 4'd8)), 0);
      chk("busy_vs_state", int'(busy), int'(state != 4'd0));
      chk("done_needs_busy", int'(done && !busy), 0);
      if (err) begin
        if (sb.size() == 0) chk("unexpected_err", 1, 0);
        else begin
          cur = sb.pop_front();
          chk($sformatf("op%0d_is_err", cur.id), int'(cur.is_err), 1);
          chk($sformatf("op%0d_err_state", cur.id), int'(state), 0);
          chk($sformatf("op%0d_err_busy", cur.id), int'(busy), 0);
        end
      end
      if (busy && !in_op) begin
        if (sb.size() == 0) chk("unexpected_op", 1, 0);
        else begin
          cur = sb.pop_front();
          chk($sformatf("op%0d_not_err", cur.id), int'(cur.is_err), 0);
          if (cur.b2b) chk($sformatf("op%0d_b2b_gap", cur.id), cyc - last_done, 2);
          obs = '{default: 0};
          in_op = 1; k = 0;
        end
      end
      if (in_op) begin
        k++;
        if (busy) obs.nbusy++;
        if (we) obs.nwe++;
        if (wwl != 0) obs.wwl_nz++;
        if (wwl != 0 && wwl == cur.wwl_v) obs.wwl_m++;
        if (rwl != 0) obs.rwl_nz++;
        if (rwl != 0 && rwl == cur.rwl_v && rwlb == cur.rwlb_v && en == cur.en_v) obs.rwl_m++;
        if (data_ready) obs.dr_k = k;
        if (saen) obs.saen_k = k;
        if (!pre_sram) obs.nsram++;
        if (!pre_vlsa) obs.nvlsa++;
        if (!pre_clsa) obs.nclsa++;
        if (pre_a == 16'd0) obs.npa0++;
        if (done || k > 40) begin
          chk($sformatf("op%0d_lat", cur.id), k, cur.lat);
          chk($sformatf("op%0d_busy", cur.id), obs.nbusy, cur.nbusy);
          chk($sformatf("op%0d_we", cur.id), obs.nwe, cur.nwe);
          chk($sformatf("op%0d_wwl_match", cur.id), obs.wwl_m, cur.wwl_m);
          chk($sformatf("op%0d_wwl_nz", cur.id), obs.wwl_nz, cur.wwl_nz);
          chk($sformatf("op%0d_rwl_match", cur.id), obs.rwl_m, cur.rwl_m);
          chk($sformatf("op%0d_rwl_nz", cur.id), obs.rwl_nz, cur.rwl_nz);
          chk($sformatf("op%0d_data_ready_k", cur.id), obs.dr_k, cur.dr_k);
          chk($sformatf("op%0d_saen_k", cur.id), obs.saen_k, cur.saen_k);
          chk($sformatf("op%0d_pre_sram", cur.id), obs.nsram, cur.nsram);
          chk($sformatf("op%0d_pre_vlsa", cur.id), obs.nvlsa, cur.nvlsa);
          chk($sformatf("op%0d_pre_clsa", cur.id), obs.nclsa, cur.nclsa);
          chk($sformatf("op%0d_pre_a_low", cur.id), obs.npa0, cur.npa0);
          chk($sformatf("op%0d_not_aborted", cur.id), int'(cur.abort), 0);
          in_op = 0;
          last_done = cyc;
        end
      end
    end
  end

  initial begin
    bit at_eval;
    start = 0; op = 0; addr = 0; ib_in = 0; col_mask = 0; reset = 0;
    repeat (2) @(posedge clk);
    #1 chk_rst("por");
    reset = 1;

    do_op(2'b00, 4'd5,  16'h0, 16'h0, 0, 0); wait_done();
    do_op(2'b01, 4'd15, 16'h0, 16'h0, 1, 0); wait_done();
    do_op(2'b10, 4'd0, 16'hA5A5, 16'h00FF, 1, 0); wait_done();
    idle(3);
    do_op(2'b11, 4'd2, 16'h0, 16'h0, 0, 0);
    idle(3);

    // A write request raised mid-read must be dropped, not queued.
    do_op(2'b00, 4'd3, 16'h0, 16'h0, 0, 0);
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; addr = 4'd9;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    idle(4);

    do_op(2'b10, 4'd0, 16'h0001, 16'h8000, 0, 0); wait_done();
    do_op(2'b01, 4'd0, 16'h0, 16'h0, 1, 0); wait_done();
    idle(2);

    do_op(2'b10, 4'd0, 16'hA5A5, 16'h00FF, 0, 1);
    at_eval = 0;
    for (int i = 0; i < 20 && !at_eval; i++) begin
      @(negedge clk);
      if (state == 4'd10) at_eval = 1;
    end
    chk("reach_imc_eval", int'(at_eval), 1);
    #2 reset = 1'b0;
    #1 chk_rst("mid_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);
    do_op(2'b00, 4'd10, 16'h0, 16'h0, 0, 0); wait_done();
    idle(4);

    chk("scoreboard_empty", sb.size(), 0);
    chk("no_open_op", int'(in_op), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
